// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the SPI load controller
package spi_pkg;

    localparam int DATA_W_DEF  = 8;
    localparam int ADDR_W_DEF  = 4;
    localparam int DMEM_SZ_DEF = 15;
    localparam int FRAME_W     = 1 + ADDR_W_DEF + DATA_W_DEF;

    localparam logic CMD_WR = 1'b1;
    localparam logic CMD_RD = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_SHIFT,
        ST_COMMIT,
        ST_READ,
        ST_WAIT_REL
    } state_t;

endpackage

// File: rtl/spi_shifter.sv
// rtl/spi_shifter.sv - serial-in frame register and parallel-load serial-out readback register
module spi_shifter import spi_pkg::*; #(
    parameter int FW = FRAME_W,
    parameter int DW = DATA_W_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          shift,
    input  logic          bit_in,
    input  logic          load,
    input  logic          out_shift,
    input  logic [DW-1:0] load_data,
    output logic [FW-1:0] frame,
    output logic          out_bit
);

    logic [DW-1:0] out_sr;

    // start clears leftovers of the previous frame so short read frames decode cleanly
    always_ff @(posedge clk) begin
        if (rst) begin
            frame  <= '0;
            out_sr <= '0;
        end else begin
            if (start) begin
                frame <= FW'(bit_in);
            end else if (shift) begin
                frame <= {frame[FW-2:0], bit_in};
            end
            if (load) begin
                out_sr <= load_data;
            end else if (out_shift) begin
                out_sr <= {out_sr[DW-2:0], 1'b0};
            end
        end
    end

    assign out_bit = out_sr[DW-1];

endmodule

// File: rtl/spi_load_ctrl.sv
// rtl/spi_load_ctrl.sv - SPI-slave frame controller and dcache-port arbiter
module spi_load_ctrl import spi_pkg::*; #(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DMEM_SZ = DMEM_SZ_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run_req,
    input  logic              csi_n,
    input  logic              csd_n,
    input  logic              mosi,
    output logic              miso,
    output logic              core_run,
    input  logic [ADDR_W-1:0] core_dc_addr,
    input  logic [DATA_W-1:0] core_dc_wdata,
    input  logic              core_dc_wen,
    output logic [ADDR_W-1:0] dc_addr,
    output logic [DATA_W-1:0] dc_wdata,
    output logic              dc_wen,
    input  logic [DATA_W-1:0] dc_rdata,
    output logic [ADDR_W-1:0] ic_addr,
    output logic [DATA_W-1:0] ic_wdata,
    output logic              ic_wen,
    output logic              frame_err
);

    localparam int FW = 1 + ADDR_W + DATA_W;
    localparam int CW = $clog2(FW + 1);
    localparam logic [ADDR_W:0] DMEM_LIM      = (ADDR_W + 1)'(DMEM_SZ);
    localparam logic [CW-1:0]   CNT_ADDR_END  = CW'(1 + ADDR_W);
    localparam logic [CW-1:0]   CNT_FRAME_END = CW'(FW);

    state_t        state, state_d;
    logic [CW-1:0] bit_cnt, cnt_d;
    logic          err_q, err_d;
    logic          is_ic_q, is_ic_d;
    logic          csi_q, csd_q;

    logic          sh_start, sh_shift, sh_load, sh_out_shift;
    logic [FW-1:0] frame;
    logic          out_bit;

    spi_shifter #(.FW(FW), .DW(DATA_W)) u_shifter (
        .clk       (clk),
        .rst       (rst),
        .start     (sh_start),
        .shift     (sh_shift),
        .bit_in    (mosi),
        .load      (sh_load),
        .out_shift (sh_out_shift),
        .load_data (dc_rdata),
        .frame     (frame),
        .out_bit   (out_bit)
    );

    // Previous cs levels reset low: a cs already low after reset is a stale frame, not a start.
    logic fall_i, fall_d, any_fall, any_low, both_low, both_high, act_cs_high;
    assign fall_i      = csi_q & ~csi_n;
    assign fall_d      = csd_q & ~csd_n;
    assign any_fall    = fall_i | fall_d;
    assign any_low     = ~csi_n | ~csd_n;
    assign both_low    = ~csi_n & ~csd_n;
    assign both_high   = csi_n & csd_n;
    assign act_cs_high = is_ic_q ? csi_n : csd_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            err_q   <= 1'b0;
            is_ic_q <= 1'b0;
            csi_q   <= 1'b0;
            csd_q   <= 1'b0;
        end else begin
            state   <= state_d;
            bit_cnt <= cnt_d;
            err_q   <= err_d;
            is_ic_q <= is_ic_d;
            csi_q   <= csi_n;
            csd_q   <= csd_n;
        end
    end

    always_comb begin
        state_d      = state;
        cnt_d        = bit_cnt;
        err_d        = 1'b0;
        is_ic_d      = is_ic_q;
        sh_start     = 1'b0;
        sh_shift     = 1'b0;
        sh_load      = 1'b0;
        sh_out_shift = 1'b0;
        case (state)
            ST_IDLE: begin
                if (run_req) begin
                    state_d = ST_RUN;
                    err_d   = any_fall;
                end else if (both_low && any_fall) begin
                    err_d   = 1'b1;
                    state_d = ST_WAIT_REL;
                end else if (any_fall) begin
                    state_d  = ST_SHIFT;
                    sh_start = 1'b1;
                    cnt_d    = CW'(1);
                    is_ic_d  = ~csi_n;
                end else if (any_low) begin
                    state_d = ST_WAIT_REL;
                end
            end
            ST_RUN: begin
                err_d = any_fall;
                if (!run_req) state_d = ST_IDLE;
            end
            ST_SHIFT: begin
                if (act_cs_high) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    sh_shift = 1'b1;
                    cnt_d    = bit_cnt + 1'b1;
                    // the cmd bit sits just above the three address bits already received
                    if (cnt_d == CNT_ADDR_END && frame[ADDR_W-1] == CMD_RD) begin
                        if (is_ic_q) begin
                            err_d   = 1'b1;
                            state_d = ST_WAIT_REL;
                        end else begin
                            state_d = ST_READ;
                        end
                    end else if (cnt_d == CNT_FRAME_END) begin
                        state_d = ST_COMMIT;
                    end
                end
            end
            ST_COMMIT: begin
                state_d = both_high ? ST_IDLE : ST_WAIT_REL;
            end
            ST_READ: begin
                if (act_cs_high) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = bit_cnt + 1'b1;
                    if (bit_cnt == CNT_ADDR_END) sh_load = 1'b1;
                    else sh_out_shift = 1'b1;
                    if (bit_cnt == CNT_FRAME_END) state_d = ST_WAIT_REL;
                end
            end
            ST_WAIT_REL: begin
                if (both_high) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    logic [ADDR_W-1:0] fr_addr, ld_addr;
    logic [DATA_W-1:0] fr_data;
    logic              in_commit, addr_ok, ld_wen;

    assign fr_addr   = frame[DATA_W +: ADDR_W];
    assign fr_data   = frame[DATA_W-1:0];
    assign in_commit = (state == ST_COMMIT) && (frame[FW-1] == CMD_WR);
    assign addr_ok   = {1'b0, fr_addr} < DMEM_LIM;
    assign ld_wen    = in_commit & ~is_ic_q & addr_ok;
    assign ld_addr   = (state == ST_READ) ? frame[ADDR_W-1:0] : fr_addr;

    assign core_run  = (state == ST_RUN);
    assign dc_addr   = core_run ? core_dc_addr  : ld_addr;
    assign dc_wdata  = core_run ? core_dc_wdata : fr_data;
    assign dc_wen    = core_run ? core_dc_wen   : ld_wen;

    assign ic_addr   = fr_addr;
    assign ic_wdata  = fr_data;
    assign ic_wen    = in_commit & is_ic_q;

    assign frame_err = err_q | (in_commit & ~is_ic_q & ~addr_ok);
    assign miso      = (state == ST_READ && bit_cnt != CNT_ADDR_END) ? out_bit : 1'b0;

endmodule

// File: tb/tb_spi_load_ctrl.sv
// tb/tb_spi_load_ctrl.sv - self-checking bench for spi_load_ctrl
module tb_spi_load_ctrl;

    localparam int N = 1024;

    logic       clk = 1'b0;
    logic       rst, run_req, csi_n, csd_n, mosi;
    logic       miso, core_run;
    logic [3:0] core_dc_addr;
    logic [7:0] core_dc_wdata;
    logic       core_dc_wen;
    logic [3:0] dc_addr, ic_addr;
    logic [7:0] dc_wdata, dc_rdata, ic_wdata;
    logic       dc_wen, ic_wen, frame_err;

    spi_load_ctrl dut (
        .clk(clk), .rst(rst), .run_req(run_req), .csi_n(csi_n), .csd_n(csd_n),
        .mosi(mosi), .miso(miso), .core_run(core_run),
        .core_dc_addr(core_dc_addr), .core_dc_wdata(core_dc_wdata), .core_dc_wen(core_dc_wen),
        .dc_addr(dc_addr), .dc_wdata(dc_wdata), .dc_wen(dc_wen), .dc_rdata(dc_rdata),
        .ic_addr(ic_addr), .ic_wdata(ic_wdata), .ic_wen(ic_wen), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] dmem [16] = '{default: 8'h00};
    always @(posedge clk) if (dc_wen) dmem[dc_addr] <= dc_wdata;
    assign dc_rdata = dmem[dc_addr];

    // expected outputs per cycle, filled by the frame-level model before the cycles occur
    logic       e_icw [N], e_dcw [N], e_err [N], e_miso [N], e_run [N], e_av [N], e_dv [N];
    logic [3:0] e_iaddr [N], e_addr [N];
    logic [7:0] e_idata [N], e_data [N];
    logic       l_ic_v [N], l_miso_v [N], l_miso [N], l_err_v [N], l_run_v [N];
    logic [11:0] l_ic [N];
    logic [7:0] model_mem [16];

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cyc >= 1 && cyc < N) begin
            chk("ic_wen",    32'(ic_wen),    32'(e_icw[cyc]));
            chk("dc_wen",    32'(dc_wen),    32'(e_dcw[cyc]));
            chk("frame_err", 32'(frame_err), 32'(e_err[cyc]));
            chk("miso",      32'(miso),      32'(e_miso[cyc]));
            chk("core_run",  32'(core_run),  32'(e_run[cyc]));
            if (e_icw[cyc]) begin
                chk("ic_addr",  32'(ic_addr),  32'(e_iaddr[cyc]));
                chk("ic_wdata", 32'(ic_wdata), 32'(e_idata[cyc]));
            end
            if (e_av[cyc]) chk("dc_addr",  32'(dc_addr),  32'(e_addr[cyc]));
            if (e_dv[cyc]) chk("dc_wdata", 32'(dc_wdata), 32'(e_data[cyc]));
            if (l_ic_v[cyc]) begin
                chk("lit_ic_wen", 32'(ic_wen), 32'd1);
                chk("lit_ic",     32'({ic_addr, ic_wdata}), 32'(l_ic[cyc]));
            end
            if (l_miso_v[cyc]) chk("lit_miso", 32'(miso), 32'(l_miso[cyc]));
            if (l_err_v[cyc]) begin
                chk("lit_err", 32'(frame_err), 32'd1);
                chk("lit_dcw", 32'(dc_wen),    32'd0);
            end
            if (l_run_v[cyc]) chk("lit_core_run", 32'(core_run), 32'd1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        csi_n = 1'b1; csd_n = 1'b1; mosi = 1'b0;
        repeat (n) tick();
    endtask

    // write frame of nbits (13 = complete, fewer = aborted by raising cs)
    task automatic write_frame(input logic is_ic, input logic [3:0] addr, input logic [7:0] data,
                               input int nbits);
        logic [12:0] f;
        int t0;
        f  = {1'b1, addr, data};
        t0 = cyc;
        if (nbits == 13) begin
            if (is_ic) begin
                e_icw[t0+13] = 1'b1; e_iaddr[t0+13] = addr; e_idata[t0+13] = data;
            end else if (addr < 4'd15) begin
                e_dcw[t0+13] = 1'b1;
                e_av[t0+13] = 1'b1; e_addr[t0+13] = addr;
                e_dv[t0+13] = 1'b1; e_data[t0+13] = data;
                model_mem[addr] = data;
            end else begin
                e_err[t0+13] = 1'b1;
            end
        end else begin
            e_err[t0+nbits+1] = 1'b1;
        end
        for (int i = 0; i < nbits; i++) begin
            csi_n = ~is_ic; csd_n = is_ic; mosi = f[12-i];
            tick();
        end
        idle(3);
    endtask

    // read frame; rst_at >= 0 pulses reset at that frame cycle
    task automatic read_frame(input logic is_ic, input logic [3:0] addr, input int rst_at);
        logic [4:0] f;
        logic [7:0] w;
        int t0;
        f  = {1'b0, addr};
        t0 = cyc;
        w  = model_mem[addr];
        if (is_ic) begin
            e_err[t0+5] = 1'b1;
        end else begin
            e_av[t0+5] = 1'b1; e_addr[t0+5] = addr;
            for (int j = 0; j < 8; j++)
                if (rst_at < 0 || 6 + j <= rst_at) e_miso[t0+6+j] = w[7-j];
        end
        for (int i = 0; i < 14; i++) begin
            csi_n = ~is_ic; csd_n = is_ic;
            mosi  = (i < 5) ? f[4-i] : 1'($urandom_range(1, 0));
            rst   = (i == rst_at);
            tick();
        end
        rst = 1'b0;
        idle(3);
    endtask

    initial begin
        logic [7:0] lit;
        int t;
        for (int i = 0; i < N; i++) begin
            e_icw[i] = 0; e_dcw[i] = 0; e_err[i] = 0; e_miso[i] = 0; e_run[i] = 0;
            e_av[i] = 0; e_dv[i] = 0; e_iaddr[i] = 0; e_addr[i] = 0; e_idata[i] = 0; e_data[i] = 0;
            l_ic_v[i] = 0; l_miso_v[i] = 0; l_miso[i] = 0; l_err_v[i] = 0; l_run_v[i] = 0; l_ic[i] = 0;
        end
        for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
        rst = 1'b1; run_req = 1'b0; csi_n = 1'b1; csd_n = 1'b1; mosi = 1'b0;
        core_dc_addr = 4'h0; core_dc_wdata = 8'h00; core_dc_wen = 1'b0;
        e_av[1] = 1'b1; e_addr[1] = 4'h0; e_dv[1] = 1'b1; e_data[1] = 8'h00;
        tick(); tick(); tick();
        rst = 1'b0;
        idle(2);

        // icache write addr 3 data A5
        l_ic_v[cyc+13] = 1'b1; l_ic[cyc+13] = 12'h3A5;
        write_frame(1'b1, 4'h3, 8'hA5, 13);

        // dcache write then readback of addr 2
        write_frame(1'b0, 4'h2, 8'h3C, 13);
        lit = 8'h3C;
        for (int j = 0; j < 8; j++) begin
            l_miso_v[cyc+6+j] = 1'b1; l_miso[cyc+6+j] = lit[7-j];
        end
        read_frame(1'b0, 4'h2, -1);

        // illegal dcache address F, then highest legal address E
        l_err_v[cyc+13] = 1'b1;
        write_frame(1'b0, 4'hF, 8'h11, 13);
        write_frame(1'b0, 4'hE, 8'h81, 13);
        read_frame(1'b0, 4'hE, -1);

        // run request together with csd_n falling; core owns the dcache port
        t = cyc;
        for (int k = 1; k <= 4; k++) begin
            e_run[t+k] = 1'b1;
            e_av[t+k] = 1'b1; e_addr[t+k] = 4'h5;
            e_dv[t+k] = 1'b1; e_data[t+k] = 8'h77;
        end
        l_run_v[t+1] = 1'b1;
        e_dcw[t+2] = 1'b1; model_mem[5] = 8'h77;
        e_err[t+1] = 1'b1; e_err[t+4] = 1'b1;
        run_req = 1'b1; csd_n = 1'b0; core_dc_addr = 4'h5; core_dc_wdata = 8'h77; core_dc_wen = 1'b1;
        tick();
        core_dc_wen = 1'b0; tick();
        core_dc_wen = 1'b1; tick();
        core_dc_wen = 1'b0; csi_n = 1'b0; tick();
        csi_n = 1'b1; run_req = 1'b0; tick();
        tick();
        idle(3);
        read_frame(1'b0, 4'h5, -1);

        // icache read is illegal
        read_frame(1'b1, 4'h3, -1);

        // abort after 7 bits, then a clean frame to addr 1
        write_frame(1'b1, 4'h7, 8'hC3, 7);
        l_ic_v[cyc+13] = 1'b1; l_ic[cyc+13] = 12'h15A;
        write_frame(1'b1, 4'h1, 8'h5A, 13);

        // both chip selects low together
        t = cyc;
        e_err[t+1] = 1'b1;
        csi_n = 1'b0; csd_n = 1'b0;
        tick(); tick(); tick();
        idle(3);
        write_frame(1'b0, 4'h0, 8'hE7, 13);

        // reset in the middle of a readback, then a normal readback
        read_frame(1'b0, 4'h2, 8);
        read_frame(1'b0, 4'h0, -1);

        idle(4);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
